// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit shared-bus datapath (Moore FSM).
// Optional memory-wait watchdog enabled by defining MEM_TIMEOUT_EN.
module control_sequencer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int ALU_LAST_OP    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       S,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PC_in,
    output logic       PC_out,
    output logic       PC_inc,
    output logic       MAR_in,
    output logic       MDR_in,
    output logic       MDR_out,
    output logic       A_in,
    output logic       C_in,
    output logic       C_out,
    output logic       IR_in,
    output logic       IR_out,
    output logic       rf_in,
    output logic       rf_out,
    output logic [1:0] rf_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       halted,
    output logic       fault,
    output logic [3:0] state_out
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_F0, ST_F1, ST_F2, ST_DEC, ST_E0, ST_E1, ST_E2, ST_HALT, ST_FAULT
    } state_t;

    // Instruction class latched at decode so the shared E-states stay Moore.
    typedef enum logic [1:0] {CL_ALU, CL_LD, CL_ST, CL_JMP} cls_t;

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d;
    logic        wait_st;
    logic        timeout;
    logic [31:0] op_ext;

    // S only affects the ALU's flag update; the sequencer has no use for it.
    wire unused_s = S;

    assign op_ext  = {28'd0, opcode};
    assign wait_st = (state_q == ST_F1) ||
                     (state_q == ST_E1 && cls_q == CL_LD) ||
                     (state_q == ST_E2 && cls_q == CL_ST);

`ifdef MEM_TIMEOUT_EN
    logic [4:0] cnt_q, cnt_d;

    // Counter restarts whenever the FSM is outside a wait state.
    always_comb begin
        cnt_d = 5'd0;
        if (wait_st && !mem_ready)
            cnt_d = cnt_q + 5'd1;
    end

    assign timeout = wait_st && !mem_ready &&
                     (({1'b0, cnt_q} + 6'd1) >= 6'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!reset)
            cnt_q <= 5'd0;
        else
            cnt_q <= cnt_d;
    end
`else
    wire [4:0] unused_timeout = 5'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cls_q   <= CL_ALU;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            ST_IDLE: state_d = ST_F0;
            ST_F0:   state_d = ST_F1;
            ST_F1:   if (mem_ready) state_d = ST_F2;
            ST_F2:   state_d = ST_DEC;
            ST_DEC: begin
                if (op_ext <= $unsigned(ALU_LAST_OP)) begin
                    cls_d   = CL_ALU;
                    state_d = ST_E0;
                end else begin
                    case (opcode)
                        4'h8: begin cls_d = CL_LD;  state_d = ST_E0; end
                        4'h9: begin cls_d = CL_ST;  state_d = ST_E0; end
                        4'hA: begin cls_d = CL_JMP; state_d = ST_E0; end
                        4'hB: begin
                            cls_d   = CL_JMP;
                            state_d = zero ? ST_E0 : ST_F0;
                        end
                        4'hF:    state_d = ST_HALT;
                        default: state_d = ST_F0;
                    endcase
                end
            end
            ST_E0:   state_d = (cls_q == CL_JMP) ? ST_F0 : ST_E1;
            ST_E1:   if (cls_q != CL_LD || mem_ready) state_d = ST_E2;
            ST_E2:   if (cls_q != CL_ST || mem_ready) state_d = ST_F0;
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
        if (timeout)
            state_d = ST_FAULT;
    end

    // Strobe decode: only one of PC_out/MDR_out/C_out/rf_out per state.
    always_comb begin
        PC_in = 1'b0; PC_out = 1'b0; PC_inc = 1'b0; MAR_in = 1'b0;
        MDR_in = 1'b0; MDR_out = 1'b0; A_in = 1'b0; C_in = 1'b0; C_out = 1'b0;
        IR_in = 1'b0; rf_in = 1'b0; rf_out = 1'b0; rf_sel = 2'd0;
        mem_rd = 1'b0; mem_wr = 1'b0; halted = 1'b0; fault = 1'b0;
        case (state_q)
            ST_F0: begin PC_out = 1'b1; MAR_in = 1'b1; end
            ST_F1: mem_rd = 1'b1;
            ST_F2: begin MDR_out = 1'b1; IR_in = 1'b1; PC_inc = 1'b1; end
            ST_E0: begin
                rf_out = 1'b1;
                rf_sel = 2'd1;
                case (cls_q)
                    CL_ALU:  A_in   = 1'b1;
                    CL_JMP:  PC_in  = 1'b1;
                    default: MAR_in = 1'b1;
                endcase
            end
            ST_E1: begin
                case (cls_q)
                    CL_ALU:  begin rf_out = 1'b1; rf_sel = 2'd2; C_in = 1'b1; end
                    CL_LD:   mem_rd = 1'b1;
                    CL_ST:   begin rf_out = 1'b1; MDR_in = 1'b1; end
                    default: ;
                endcase
            end
            ST_E2: begin
                case (cls_q)
                    CL_ALU:  begin C_out = 1'b1; rf_in = 1'b1; end
                    CL_LD:   begin MDR_out = 1'b1; rf_in = 1'b1; end
                    CL_ST:   mem_wr = 1'b1;
                    default: ;
                endcase
            end
            ST_HALT:  halted = 1'b1;
            ST_FAULT: fault  = 1'b1;
            default: ;
        endcase
    end

    assign IR_out    = 1'b0;
    assign state_out = state_q;

endmodule
